// File: rtl/lfsr_prbs_stream_pkg.sv
// Shared types for the streaming PRBS source
// and its combinational LFSR core.
package lfsr_prbs_stream_pkg;

  typedef enum logic {
    CFG_FIBONACCI,
    CFG_GALOIS
  } lfsr_cfg_e;

endpackage

// File: rtl/lfsr_prbs_stream_lfsr.sv
// Combinational LFSR: advances state_in by
// DATA_WIDTH bit steps and returns the bits shifted out.
module lfsr
  import lfsr_prbs_stream_pkg::*;
#(
  parameter int LFSR_WIDTH = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY =
    31'h10000001,
  parameter string LFSR_CONFIG = "FIBONACCI",
  parameter bit LFSR_FEED_FORWARD = 1'b0,
  parameter bit REVERSE = 1'b0,
  parameter int DATA_WIDTH = 8,
  parameter string STYLE = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam lfsr_cfg_e CFG =
    (LFSR_CONFIG == "GALOIS") ? CFG_GALOIS
                              : CFG_FIBONACCI;

  if (LFSR_CONFIG != "FIBONACCI" &&
      LFSR_CONFIG != "GALOIS") begin : g_bad_cfg
    $error("lfsr: unknown LFSR_CONFIG");
  end

  if (STYLE != "AUTO" && STYLE != "LOOP" &&
      STYLE != "REDUCTION") begin : g_bad_style
    $error("lfsr: unknown STYLE");
  end

  logic [LFSR_WIDTH-1:0] s;
  logic [DATA_WIDTH-1:0] o;
  logic                  fb;
  logic                  sh;

  // Input data is consumed MSB first, as is the output.
  always_comb begin
    s  = state_in;
    o  = '0;
    fb = 1'b0;
    sh = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = s[LFSR_WIDTH-1] ^ data_in[i];
      if (CFG == CFG_FIBONACCI) begin
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) fb = fb ^ s[j-1];
        end
      end
      o    = o << 1;
      o[0] = fb;
      sh   = LFSR_FEED_FORWARD ? data_in[i] : fb;
      s    = s << 1;
      s[0] = sh;
      if (CFG == CFG_GALOIS) begin
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) s[j] = s[j] ^ sh;
        end
      end
    end
  end

  always_comb begin
    data_out = o;
    if (REVERSE) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        data_out[i] = o[DATA_WIDTH-1-i];
      end
    end
  end

  assign state_out = s;

endmodule

// File: rtl/lfsr_prbs_stream.sv
// PRBS word source with valid/ready output, seed
// loading, inversion, error injection and counters.
module lfsr_prbs_stream
  import lfsr_prbs_stream_pkg::*;
#(
  parameter int LFSR_WIDTH = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY =
    31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT = '1,
  parameter string LFSR_CONFIG = "FIBONACCI",
  parameter bit REVERSE = 1'b0,
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_WIDTH = 32,
  parameter string STYLE = "AUTO"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   seed_load,
  input  logic [LFSR_WIDTH-1:0]  seed_data,
  input  logic                   invert,
  input  logic                   err_inject,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [COUNT_WIDTH-1:0] inject_count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [LFSR_WIDTH-1:0] state_reg;
  logic [LFSR_WIDTH-1:0] lfsr_state;
  logic [DATA_WIDTH-1:0] lfsr_data;
  logic [DATA_WIDTH-1:0] zero_data;
  logic [DATA_WIDTH-1:0] flip;
  logic                  err_pending;
  logic                  slot_free;
  logic                  gen;
  logic                  inject;

  assign zero_data = '0;
  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign gen       = !seed_load && slot_free && enable;
  assign inject    = err_inject || err_pending;
  assign flip      = {DATA_WIDTH{invert}} ^
                     DATA_WIDTH'(inject);

  lfsr #(
    .LFSR_WIDTH       (LFSR_WIDTH),
    .LFSR_POLY        (LFSR_POLY),
    .LFSR_CONFIG      (LFSR_CONFIG),
    .LFSR_FEED_FORWARD(1'b0),
    .REVERSE          (REVERSE),
    .DATA_WIDTH       (DATA_WIDTH),
    .STYLE            (STYLE)
  ) u_lfsr (
    .data_in  (zero_data),
    .state_in (state_reg),
    .data_out (lfsr_data),
    .state_out(lfsr_state)
  );

  // A zero seed would lock the LFSR, so it maps to INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= LFSR_INIT;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      err_pending   <= 1'b0;
    end else if (seed_load) begin
      state_reg     <= (seed_data == '0) ? LFSR_INIT
                                         : seed_data;
      m_axis_tvalid <= 1'b0;
      err_pending   <= 1'b0;
    end else if (gen) begin
      m_axis_tdata  <= lfsr_data ^ flip;
      m_axis_tvalid <= 1'b1;
      state_reg     <= lfsr_state;
      err_pending   <= 1'b0;
    end else begin
      if (slot_free) m_axis_tvalid <= 1'b0;
      if (err_inject) err_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      word_count   <= '0;
      inject_count <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready &&
          word_count != CNT_MAX) begin
        word_count <= word_count + COUNT_WIDTH'(1);
      end
      if (gen && inject &&
          inject_count != CNT_MAX) begin
        inject_count <= inject_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule
